// File: rtl/wshb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the arbiter state encoding, master indices and the default hold quota.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_QUOTA = 64;

endpackage

// File: rtl/wshb_arbiter_if.sv
// Classic Wishbone bundle; master drives the request side, slave returns ack/data.
// No pipelining, no stall, no err/retry: a transfer completes on ack.
interface wshb_if #(
    parameter int AW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat_ms;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic [31:0]   dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_arbiter_mux.sv
// Two-to-one Wishbone mux steered by the arbiter state; purely combinational, zero latency.
// Backpressure: ack is routed only to the selected master, read data is broadcast.
module wshb_arb_mux
    import wshb_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  arb_state_e  state_i,
    wshb_if.slave       s0,
    wshb_if.slave       s1,
    wshb_if.master      m
);

    logic [AW-1:0] adr_mux;

    always_comb begin
        m.cyc    = 1'b0;
        m.stb    = 1'b0;
        m.we     = 1'b0;
        adr_mux  = '0;
        m.dat_ms = '0;
        m.sel    = '0;
        m.cti    = '0;
        m.bte    = '0;
        s0.ack   = 1'b0;
        s1.ack   = 1'b0;
        case (state_i)
            GNT0: begin
                m.cyc    = s0.cyc;
                // stb is qualified by cyc so the slave never sees a stray strobe
                m.stb    = s0.cyc & s0.stb;
                m.we     = s0.we;
                adr_mux  = s0.adr;
                m.dat_ms = s0.dat_ms;
                m.sel    = s0.sel;
                m.cti    = s0.cti;
                m.bte    = s0.bte;
                s0.ack   = m.ack;
            end
            GNT1: begin
                m.cyc    = s1.cyc;
                m.stb    = s1.cyc & s1.stb;
                m.we     = s1.we;
                adr_mux  = s1.adr;
                m.dat_ms = s1.dat_ms;
                m.sel    = s1.sel;
                m.cti    = s1.cti;
                m.bte    = s1.bte;
                s1.ack   = m.ack;
            end
            default: ;
        endcase
    end

    assign m.adr     = adr_mux;
    assign s0.dat_sm = m.dat_sm;
    assign s1.dat_sm = m.dat_sm;

endmodule

// File: rtl/wshb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between two masters with a per-grant ack quota.
// Grant 1 cycle after request from IDLE, 0-cycle handover; losing master stalls with cyc held.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int QUOTA = DEFAULT_QUOTA,
    parameter int AW    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    localparam int HW = $clog2(QUOTA + 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(QUOTA);
    localparam logic [HW-1:0] HCNT_LAST = HW'(QUOTA - 1);

    arb_state_e    state_q, state_d, mux_state;
    logic          last_gnt_q, last_gnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          c0, c1, slv_ack, quota_hit;

    assign c0      = wshb_ifs0.cyc;
    assign c1      = wshb_ifs1.cyc;
    assign slv_ack = wshb_ifm.ack;
    // >= also covers a saturated counter when the other master shows up late
    assign quota_hit = slv_ack && (hcnt_q >= HCNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (c0 && c1)  state_d = (last_gnt_q == M0) ? GNT1 : GNT0;
                else if (c0)   state_d = GNT0;
                else if (c1)   state_d = GNT1;
            end
            GNT0: begin
                if (!c0)                  state_d = c1 ? GNT1 : IDLE;
                else if (c1 && quota_hit) state_d = GNT1;
            end
            GNT1: begin
                if (!c1)                  state_d = c0 ? GNT0 : IDLE;
                else if (c0 && quota_hit) state_d = GNT0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hcnt_d     = hcnt_q;
        last_gnt_d = last_gnt_q;
        if (state_d != state_q) begin
            hcnt_d = '0;
            if (state_d == GNT0) last_gnt_d = M0;
            if (state_d == GNT1) last_gnt_d = M1;
        end else if (state_q != IDLE && slv_ack && hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + HW'(1);
        end
        grant_d = {state_d == GNT1, state_d == GNT0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= M1;
            hcnt_q     <= '0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hcnt_q     <= hcnt_d;
            grant_q    <= grant_d;
        end
    end

    // Reset closes the bus in the same cycle, so an in-flight ack is dropped
    assign mux_state = rst_n ? state_q : IDLE;
    assign grant     = rst_n ? grant_q : 2'b00;

    wshb_arb_mux #(.AW(AW)) u_mux (
        .state_i (mux_state),
        .s0      (wshb_ifs0),
        .s1      (wshb_ifs1),
        .m       (wshb_ifm)
    );

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter QUOTA, default 64, SHALL set the max consecutive acked transfers granted to one master while the other requests.
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 clk  input  1  SHALL be the single clock for all logic; it is the Wishbone clock of all three ports.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 wshb_ifs0  wshb_if.slave  bundle  SHALL be master 0 (video reader), with cyc, stb, we, adr[AW-1:0], dat_ms[31:0], sel[3:0], cti[2:0], bte[1:0] in, and ack, dat_sm[31:0] out.
REQ-006 wshb_ifs1  wshb_if.slave  bundle  SHALL be master 1 (pattern/CPU writer), with the same signal set as wshb_ifs0.
REQ-007 wshb_ifm  wshb_if.master  bundle  SHALL drive the shared SDRAM controller, with the same signal set in the opposite direction.
REQ-008 grant  output  2  SHALL flag the granted master, one-hot: bit0 for master 0, bit1 for master 1, 00 when idle.

Function
REQ-009 Classic Wishbone (non-pipelined) on all ports: each transfer ends on ack; no retry/err.
REQ-010 FSM states SHALL be IDLE, GNT0, GNT1, held in a registered state; all muxing SHALL be combinational from the state.
REQ-011 IDLE: with only master n's cyc high, go to GNTn next edge. With both high, grant the master not in last_gnt. With none, stay IDLE.
REQ-012 GNTn: master n's cyc low and master m's cyc high -> GNTm. Master n's cyc low and master m's cyc low -> IDLE. Otherwise stay in GNTn, except per REQ-014.
REQ-013 Hold counter hcnt, $clog2(QUOTA+1) bits, SHALL clear on every grant change and increment on each slave ack in GNTn; it saturates at QUOTA.
REQ-014 In GNTn, on a cycle with slave ack, hcnt==QUOTA-1 and master m's cyc high, go to GNTm at that edge (preemption). The preempted master keeps cyc/stb and receives no ack until it is re-granted.
REQ-015 last_gnt SHALL update to n on every entry to GNTn.
REQ-016 In GNTn, the slave cyc, stb, we, adr, dat_ms, sel, cti and bte SHALL equal master n's signals. In IDLE, the slave cyc and stb SHALL be 0, with the remaining fields also 0.
REQ-017 The slave ack SHALL route only to the granted master; the other master's ack SHALL be 0. The slave dat_sm SHALL be broadcast to both masters.
REQ-018 Grant latency: master cyc rise in IDLE -> slave cyc high on the next cycle (1 cycle). Switch latency on release or preemption: 0 idle cycles between the two grants.
REQ-019 Slave stb SHALL never be high while slave cyc is low.
REQ-020 A slave ack arriving in the same cycle as the granted master drops cyc SHALL still be delivered to that master. The transition SHALL follow REQ-012.
REQ-021 QUOTA=1 SHALL give strict alternation per transfer when both masters request continuously.

Reset
REQ-022 While rst_n=0 at clk edge: state=IDLE, last_gnt=1 (master 0 wins the first tie), hcnt=0.
REQ-023 During and after reset until the first grant: slave cyc=stb=0, both acks 0, grant=00.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no ack forwarded. The arbiter SHALL restart from IDLE on the first cycle with rst_n=1.

Structure
REQ-025 Package wshb_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1), master index constants M0=0 and M1=1, and the default QUOTA.
REQ-026 Sub-module wshb_arb_mux (combinational two-to-one Wishbone mux selected by state) SHALL be instantiated once. The FSM, last_gnt and hcnt SHALL stay in wshb_arbiter.

Verification
REQ-027 Reset, then master 0 alone reads 4 words with a slave acking every cycle -> slave cyc high 1 cycle after master 0 cyc, 4 acks to master 0, master 1 ack always 0.
REQ-028 Both cyc rise in the same cycle after reset -> GNT0 first. After master 0 releases with 3 transfers done, GNT1 with zero idle cycles between.
REQ-029 QUOTA=4, both requesting continuously -> grant sequence 0,1,0,1 with exactly 4 acks per grant. Slave adr always matches the granted master.
REQ-030 Slave ack in the same cycle master 1 drops cyc -> master 1 receives that ack and the arbiter goes to IDLE (or GNT0 if master 0 requests).
REQ-031 rst_n low for 1 cycle during GNT1 with a pending stb -> next cycle state=IDLE, slave cyc=0, no ack forwarded, then normal re-arbitration.
REQ-032 Master 0 holds cyc for 1000 cycles with master 1 idle -> no preemption, hcnt saturates at QUOTA, grant stays 01.
